// File: rtl/imm_pkg.sv
// Shared types and constants for the immediate decode stage.
// Optional feature macro: ILLEGAL_DETECT_EN (adds the illegal-opcode flag).
package imm_pkg;

   localparam int XLEN_C = 32;

   // RV32I major opcodes, inst[6:0]
   localparam logic [6:0] OPC_R      = 7'b0110011;
   localparam logic [6:0] OPC_I_ALU  = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   // Operand-B select codes
   localparam logic [1:0] SEL_RS2 = 2'b00;
   localparam logic [1:0] SEL_I   = 2'b01;
   localparam logic [1:0] SEL_S   = 2'b10;
   localparam logic [1:0] SEL_B   = 2'b11;

   // One decoded buffer entry
   typedef struct packed {
      logic [1:0]        sel;
      logic [XLEN_C-1:0] i;
      logic [XLEN_C-1:0] s;
      logic [XLEN_C-1:0] b;
      logic              illegal;
   } imm_entry_t;

   // Buffer occupancy states
   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_ONE   = 2'b01,
      ST_FULL  = 2'b10
   } occ_e;

   // Opcode to operand-B select; anything unlisted uses rs2
   function automatic logic [1:0] sel_of(input logic [6:0] opc);
      logic [1:0] sel;
      case (opc)
         OPC_I_ALU, OPC_LOAD, OPC_JALR: sel = SEL_I;
         OPC_STORE:                     sel = SEL_S;
         OPC_BRANCH:                    sel = SEL_B;
         default:                       sel = SEL_RS2;
      endcase
      return sel;
   endfunction

   // True for every RV32I base opcode this core recognises
   function automatic logic is_known_opcode(input logic [6:0] opc);
      logic known;
      case (opc)
         OPC_R, OPC_I_ALU, OPC_LOAD, OPC_JALR, OPC_STORE, OPC_BRANCH,
         OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_SYSTEM: known = 1'b1;
         default:                                 known = 1'b0;
      endcase
      return known;
   endfunction

   // Number of valid entries held in a given state
   function automatic int unsigned occupancy(input occ_e st);
      int unsigned n;
      case (st)
         ST_ONE:  n = 1;
         ST_FULL: n = 2;
         default: n = 0;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational decode of one RV32I word into a buffer entry: operand-B
// select plus the I, S and B immediates, all built from the same word.
// Optional feature macro: ILLEGAL_DETECT_EN (fills in entry_o.illegal).
module imm_gen
   import imm_pkg::*;
(
   input  logic [31:0] inst_i,
   output imm_entry_t  entry_o
);

   logic [6:0] opc;

   assign opc = inst_i[6:0];

   // Decode select and build all three immediates unconditionally
   always_comb begin
      entry_o         = '0;
      entry_o.sel     = sel_of(opc);
      entry_o.i       = {{20{inst_i[31]}}, inst_i[31:20]};
      entry_o.s       = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
      entry_o.b       = {{19{inst_i[31]}}, inst_i[31], inst_i[7],
                         inst_i[30:25], inst_i[11:8], 1'b0};
`ifdef ILLEGAL_DETECT_EN
      entry_o.illegal = !is_known_opcode(opc) || (inst_i[1:0] != 2'b11);
      if (entry_o.illegal) begin
         entry_o.sel = SEL_RS2;
      end
`else
      entry_o.illegal = 1'b0;
`endif
   end

endmodule

// File: rtl/imm_decode_stage.sv
// Pipelined operand-B select / immediate producer with a 2-entry skid
// buffer. in_ready comes straight from a flop, so there is no combinational
// path from out_ready back to in_ready, yet full throughput is kept.
// Optional feature macro: ILLEGAL_DETECT_EN (adds the illegal output).
//
//  state    | meaning
//  ---------+--------------------------------------------------------
//  ST_EMPTY | nothing buffered; out_valid=0, in_ready=1
//  ST_ONE   | output register holds an entry; in_ready=1
//  ST_FULL  | output and skid registers both hold entries; in_ready=0
module imm_decode_stage
   import imm_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in_inst,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [1:0]      imme_sel,
   output logic [XLEN-1:0] i_imme,
   output logic [XLEN-1:0] s_imme,
   output logic [XLEN-1:0] b_imme
`ifdef ILLEGAL_DETECT_EN
   ,
   output logic            illegal
`endif
);

   occ_e       state_q;
   imm_entry_t out_q;
   imm_entry_t skid_q;
   imm_entry_t dec;
   logic       in_ready_q;
   logic       out_valid_q;
   logic       accept;
   logic       drain;

   // Decoder sits on the input so both registers store finished entries
   imm_gen u_imm_gen (
      .inst_i  (in_inst),
      .entry_o (dec)
   );

   assign accept = in_valid && in_ready_q;
   assign drain  = out_valid_q && out_ready;

   // Occupancy FSM with registered handshake flags and data moves
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_EMPTY;
         out_q       <= '0;
         skid_q      <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else if (flush) begin
         // Data registers keep their contents; only validity is dropped.
         state_q     <= ST_EMPTY;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (accept) begin
                  out_q       <= dec;
                  out_valid_q <= 1'b1;
                  state_q     <= ST_ONE;
               end
            end
            ST_ONE: begin
               if (accept && drain) begin
                  out_q <= dec;
               end else if (accept) begin
                  skid_q     <= dec;
                  in_ready_q <= 1'b0;
                  state_q    <= ST_FULL;
               end else if (drain) begin
                  out_valid_q <= 1'b0;
                  state_q     <= ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (drain) begin
                  out_q      <= skid_q;
                  in_ready_q <= 1'b1;
                  state_q    <= ST_ONE;
               end
            end
            default: begin
               state_q     <= ST_EMPTY;
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
            end
         endcase
      end
   end

   // Occupancy stays within the buffer and the ready flag matches the state
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (occupancy(state_q) <= DEPTH);
         assert (in_ready_q == (state_q != ST_FULL));
         assert (out_valid_q == (state_q != ST_EMPTY));
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign imme_sel  = out_q.sel;
   assign i_imme    = out_q.i;
   assign s_imme    = out_q.s;
   assign b_imme    = out_q.b;

`ifdef ILLEGAL_DETECT_EN
   assign illegal = out_q.illegal;
`else
   logic unused_illegal;
   assign unused_illegal = out_q.illegal ^ skid_q.illegal;
`endif

endmodule

// File: tb/tb_imm_decode_stage.sv
// Self-checking bench for imm_decode_stage: decode vector table, handwritten
// handshake corner cases and a randomized run against a queue-based model.
module tb_imm_decode_stage;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_inst;
   logic        out_valid;
   logic        out_ready;
   logic [1:0]  imme_sel;
   logic [31:0] i_imme;
   logic [31:0] s_imme;
   logic [31:0] b_imme;
`ifdef ILLEGAL_DETECT_EN
   logic        illegal;
`endif

   int checks;
   int failures;

   imm_decode_stage dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_inst   (in_inst),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .imme_sel  (imme_sel),
      .i_imme    (i_imme),
      .s_imme    (s_imme),
      .b_imme    (b_imme)
`ifdef ILLEGAL_DETECT_EN
      ,
      .illegal   (illegal)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: FIFO of raw words, capacity 2, ready registered
   logic [31:0] mq[$];
   bit          m_ready;

   typedef struct {
      logic [1:0]  sel;
      logic [31:0] i;
      logic [31:0] s;
      logic [31:0] b;
      logic        ill;
   } ref_t;

   function automatic ref_t ref_decode(input logic [31:0] w);
      ref_t r;
      int   opc;
      int   ival, sval, bval;
      bit   known;
      opc  = int'(w[6:0]);
      ival = int'(w[31:20]);
      if (ival >= 2048) ival = ival - 4096;
      sval = int'(w[31:25]) * 32 + int'(w[11:7]);
      if (sval >= 2048) sval = sval - 4096;
      bval = int'(w[31]) * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32
             + int'(w[11:8]) * 2;
      if (bval >= 4096) bval = bval - 8192;
      r.i = 32'(ival);
      r.s = 32'(sval);
      r.b = 32'(bval);
      if (opc == 'h13 || opc == 'h03 || opc == 'h67) r.sel = 2'd1;
      else if (opc == 'h23)                          r.sel = 2'd2;
      else if (opc == 'h63)                          r.sel = 2'd3;
      else                                           r.sel = 2'd0;
      known = (opc == 'h33 || opc == 'h13 || opc == 'h03 || opc == 'h67 ||
               opc == 'h23 || opc == 'h63 || opc == 'h37 || opc == 'h17 ||
               opc == 'h6F || opc == 'h73);
      r.ill = !known || (w[1:0] != 2'b11);
`ifdef ILLEGAL_DETECT_EN
      if (r.ill) r.sel = 2'd0;
`endif
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Advance one clock, update the model, then compare everything
   task automatic tick();
      bit   acc, drn;
      ref_t r;
      acc = in_valid && m_ready;
      drn = (mq.size() > 0) && out_ready;
      @(posedge clk);
      if (rst || flush) begin
         mq.delete();
      end else begin
         if (drn) void'(mq.pop_front());
         if (acc) mq.push_back(in_inst);
      end
      m_ready = (mq.size() < 2);
      #1;
      chk("in_ready", {31'd0, in_ready}, {31'd0, m_ready});
      chk("out_valid", {31'd0, out_valid}, {31'd0, mq.size() > 0});
      if (mq.size() > 0) begin
         r = ref_decode(mq[0]);
         chk("model_sel", {30'd0, imme_sel}, {30'd0, r.sel});
         chk("model_i", i_imme, r.i);
         chk("model_s", s_imme, r.s);
         chk("model_b", b_imme, r.b);
`ifdef ILLEGAL_DETECT_EN
         chk("model_illegal", {31'd0, illegal}, {31'd0, r.ill});
`endif
      end
   endtask

   typedef struct {
      logic [31:0] inst;
      logic [1:0]  sel;
      logic [31:0] i;
      logic [31:0] s;
      logic [31:0] b;
      logic        ill;
   } vec_t;

   vec_t vecs[9];

   initial begin
      logic [31:0] w_a, w_b, w_c;

      checks   = 0;
      failures = 0;
      m_ready  = 1'b1;

      // Decode vectors; illegal words decode with sel=00 in either build
      vecs[0] = '{32'hFFF00093, 2'b01, 32'hFFFFFFFF, 32'hFFFFFFE1, 32'hFFFFFFE0, 1'b0};
      vecs[1] = '{32'hFE112E23, 2'b10, 32'hFFFFFFE1, 32'hFFFFFFFC, 32'hFFFFF7FC, 1'b0};
      vecs[2] = '{32'hFE000EE3, 2'b11, 32'hFFFFFFE0, 32'hFFFFFFFD, 32'hFFFFFFFC, 1'b0};
      vecs[3] = '{32'h002081B3, 2'b00, 32'h00000002, 32'h00000003, 32'h00000802, 1'b0};
      vecs[4] = '{32'h00812083, 2'b01, 32'h00000008, 32'h00000001, 32'h00000800, 1'b0};
      vecs[5] = '{32'h000080E7, 2'b01, 32'h00000000, 32'h00000001, 32'h00000800, 1'b0};
      vecs[6] = '{32'h123450B7, 2'b00, 32'h00000123, 32'h00000121, 32'h00000920, 1'b0};
      vecs[7] = '{32'h0000007F, 2'b00, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1};
      vecs[8] = '{32'h00000090, 2'b00, 32'h00000000, 32'h00000001, 32'h00000800, 1'b1};

      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_inst = '0; out_ready = 1'b0;
      tick();
      tick();
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_sel", {30'd0, imme_sel}, 32'd0);
      chk("rst_i", i_imme, 32'd0);
      chk("rst_s", s_imme, 32'd0);
      chk("rst_b", b_imme, 32'd0);
      rst = 1'b0;
      tick();
      chk("idle_out_valid", {31'd0, out_valid}, 32'd0);

      // Table: each word alone, appears one cycle after accept
      out_ready = 1'b1;
      for (int k = 0; k < 9; k++) begin
         in_valid = 1'b1; in_inst = vecs[k].inst;
         tick();
         in_valid = 1'b0;
         chk("vec_valid", {31'd0, out_valid}, 32'd1);
         chk("vec_sel", {30'd0, imme_sel}, {30'd0, vecs[k].sel});
         chk("vec_i", i_imme, vecs[k].i);
         chk("vec_s", s_imme, vecs[k].s);
         chk("vec_b", b_imme, vecs[k].b);
`ifdef ILLEGAL_DETECT_EN
         chk("vec_illegal", {31'd0, illegal}, {31'd0, vecs[k].ill});
`endif
         tick();
      end

      // Store then branch back-to-back, one word per cycle
      in_valid = 1'b1; in_inst = 32'hFE112E23;
      tick();
      chk("bb_store_sel", {30'd0, imme_sel}, 32'd2);
      chk("bb_store_s", s_imme, 32'hFFFFFFFC);
      in_inst = 32'hFE000EE3;
      tick();
      chk("bb_branch_valid", {31'd0, out_valid}, 32'd1);
      chk("bb_branch_sel", {30'd0, imme_sel}, 32'd3);
      chk("bb_branch_b", b_imme, 32'hFFFFFFFC);
      in_valid = 1'b0;
      tick();

      // Back-pressure: three attempts, two accepted, drain in order
      w_a = 32'h00100093; w_b = 32'h00200113; w_c = 32'h00300193;
      out_ready = 1'b0; in_valid = 1'b1;
      in_inst = w_a; tick();
      chk("bp_ready_after1", {31'd0, in_ready}, 32'd1);
      in_inst = w_b; tick();
      chk("bp_ready_after2", {31'd0, in_ready}, 32'd0);
      chk("bp_hold_first", i_imme, 32'd1);
      in_inst = w_c; tick();
      chk("bp_still_first", i_imme, 32'd1);
      in_valid = 1'b0; out_ready = 1'b1;
      tick();
      chk("bp_second_i", i_imme, 32'd2);
      chk("bp_ready_back", {31'd0, in_ready}, 32'd1);
      tick();
      chk("bp_drained", {31'd0, out_valid}, 32'd0);

      // Flush while FULL with a word offered in the same cycle
      out_ready = 1'b0; in_valid = 1'b1;
      in_inst = w_a; tick();
      in_inst = w_b; tick();
      flush = 1'b1; in_inst = w_c; tick();
      flush = 1'b0; in_valid = 1'b0;
      chk("fl_out_valid", {31'd0, out_valid}, 32'd0);
      chk("fl_in_ready", {31'd0, in_ready}, 32'd1);
      out_ready = 1'b1;
      tick(); tick();
      chk("fl_word_gone", {31'd0, out_valid}, 32'd0);

      // Reset while FULL
      out_ready = 1'b0; in_valid = 1'b1;
      in_inst = w_a; tick();
      in_inst = w_b; tick();
      rst = 1'b1; flush = 1'b1; tick();
      rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
      chk("rstfull_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rstfull_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rstfull_i", i_imme, 32'd0);

      // Randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 40) == 0);
         rst       = ($urandom_range(0, 400) == 0);
         if ($urandom_range(0, 1) == 1)
            in_inst = vecs[$urandom_range(0, 8)].inst ^ {$urandom_range(0, 32'h1FFFFFF), 7'd0};
         else
            in_inst = $urandom;
         tick();
      end
      rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      tick(); tick(); tick();
      chk("end_empty", {31'd0, out_valid}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/imm_decode_stage.md
Name: imm_decode_stage

Overview:
- Pipelined producer of operand-B select and immediates for the ALU operand mux.
- Accepts raw 32-bit RV32I instruction words over valid/ready and decodes the opcode into imme_sel.
- Builds I, S and B immediates and presents them registered, one cycle later, to the execute side.
- Includes a 2-entry skid buffer, so in_ready is a registered signal and full throughput holds under back-pressure.

Parameters:
- XLEN, 32, datapath/immediate width; only 32 is supported.
- DEPTH, 2, skid buffer entries; fixed at 2, parameter kept for assertions only.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  drop all buffered entries (branch redirect).
- in_valid  input  1  instruction word valid.
- in_ready  output  1  stage can accept; registered.
- in_inst  input  32  instruction word.
- out_valid  output  1  decoded entry valid.
- out_ready  input  1  consumer accepts.
- imme_sel  output  2  00 rs2, 01 I-imm, 10 S-imm, 11 B-imm.
- i_imme  output  32  sign-extended inst[31:20].
- s_imme  output  32  sign-extended {inst[31:25], inst[11:7]}.
- b_imme  output  32  sign-extended {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}.
- illegal  output  1  present only with ILLEGAL_DETECT_EN.

Behaviour:
- Reset (sync, rst=1 at posedge): state EMPTY, out_valid=0, in_ready=1, imme_sel=00, all immediates=0, illegal=0. Reset overrides flush and any handshake in the same cycle.
- Opcode map, inst[6:0]:
  - 0110011 gives 00.
  - 0010011, 0000011 and 1100111 give 01.
  - 0100011 gives 10.
  - 1100011 gives 11.
  - Any other opcode gives 00.
- All three immediates are always computed from the same word, regardless of imme_sel.
- Accept event: in_valid & in_ready at posedge. Drain event: out_valid & out_ready at posedge.
- Latency: an accepted word appears on the outputs the next cycle when the buffer was EMPTY. Throughput is 1/cycle while out_ready=1.
- State machine (entry count):
  - EMPTY: accept goes to ONE (entry to output register).
  - ONE:
    - Accept without drain goes to FULL (entry to skid register).
    - Accept with drain stays ONE (new entry replaces output).
    - Drain only goes to EMPTY.
  - FULL: in_ready=0. Drain goes to ONE (skid moves to output). No accept is possible.
- in_ready is registered: 1 in EMPTY and ONE, 0 in FULL. There are no combinational paths from out_ready to in_ready.
- Outputs hold stable while out_valid=1 and out_ready=0.
- flush=1 at posedge: go to EMPTY and drop any accept in that cycle. out_valid=0 and in_ready=1 next cycle. Output data is don't-care but holds its last value.
- Order is strictly FIFO; no entry is dropped or duplicated except by flush or rst.

Optional Feature:
- Macro ILLEGAL_DETECT_EN.
- Defined: adds the illegal output, registered alongside the entry. It is 1 when the opcode is outside {0110011, 0010011, 0000011, 1100111, 0100011, 1100011, 0110111, 0010111, 1101111, 1110011}, or inst[1:0]!=11. The entry still flows with imme_sel=00.
- Undefined: port absent, no extra logic.

Decomposition:
- Package imm_pkg holds:
  - Opcode constants OPC_R, OPC_I_ALU, OPC_LOAD, OPC_JALR, OPC_STORE, OPC_BRANCH.
  - Select constants SEL_RS2, SEL_I, SEL_S, SEL_B.
  - Entry struct {sel, i, s, b, illegal}.
- Sub-module imm_gen: combinational decode of one word into an entry. It is instantiated once, on in_inst, so both registers store decoded entries.

Test Plan:
- Reset then idle: out_valid=0, in_ready=1, all immediates 0. Assert rst mid-FULL: next cycle EMPTY, in_ready=1.
- Single word 0xFFF00093 (addi x1,x0,-1), out_ready=1: next cycle out_valid=1, imme_sel=01, i_imme=0xFFFFFFFF.
- Store 0xFE112E23 then branch 0xFE000EE3 back-to-back:
  - Store gives sel=10, s_imme=0xFFFFFFFC.
  - Branch gives sel=11, b_imme=0xFFFFFFFC.
  - One word per cycle.
- out_ready=0, three accept attempts:
  - First two are accepted; in_ready drops to 0 after the second.
  - Outputs hold the first word.
  - Raising out_ready drains in order with no loss.
- flush while FULL with in_valid=1: next cycle out_valid=0, in_ready=1, and the flushed-cycle word never appears.
- ILLEGAL_DETECT_EN defined, word 0x0000007F: illegal=1, sel=00. R-type 0x002081B3: illegal=0, sel=00.
